// File: rtl/cart_bus_pkg.sv
// Shared constants, types and width helpers for the cartridge-bus controller.
package cart_bus_pkg;

    localparam int unsigned AW_DEF     = 16;
    localparam int unsigned DW_DEF     = 8;
    localparam int unsigned NCH_DEF    = 2;
    localparam int unsigned PHASES_DEF = 4;

    // One requester's access at the default bus widths.
    typedef struct packed {
        logic              write;
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] wdata;
    } cart_req_t;

    // Bus-cycle ownership: idle during phase 0, busy from accept to wrap.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } bus_state_e;

    // Phase counter width, never narrower than one bit.
    function automatic int unsigned phase_width(input int unsigned phases);
        int unsigned w;
        w = 32'($clog2(phases));
        return (w < 1) ? 1 : w;
    endfunction

    // Requester index width, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = 32'($clog2(n));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/cart_bus_if.sv
// Requester-side and cartridge-pin signals of the bus controller.
interface cart_bus_if
    import cart_bus_pkg::*;
#(
    parameter int unsigned AW  = AW_DEF,
    parameter int unsigned DW  = DW_DEF,
    parameter int unsigned NCH = NCH_DEF,
    parameter int unsigned PW  = phase_width(PHASES_DEF)
);
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    write;
    logic [NCH*AW-1:0] addr;
    logic [NCH*DW-1:0] wdata;
    logic [NCH-1:0]    grant;
    logic [NCH-1:0]    rvalid;
    logic [DW-1:0]     rdata;
    logic [PW-1:0]     t;
    logic              n_cart_clk;
    logic              cart_write;
    logic              cart_read;
    logic              cart_cs;
    logic [AW-1:0]     cart_addr;
    logic [DW-1:0]     cart_wdata;
    logic              cart_wdata_send;
    logic [DW-1:0]     cart_rdata;

    // Requesters and the cartridge model drive the controller's inputs.
    modport master (
        output req, write, addr, wdata, cart_rdata,
        input  grant, rvalid, rdata, t, n_cart_clk, cart_write, cart_read,
               cart_cs, cart_addr, cart_wdata, cart_wdata_send
    );

    // The controller itself.
    modport slave (
        input  req, write, addr, wdata, cart_rdata,
        output grant, rvalid, rdata, t, n_cart_clk, cart_write, cart_read,
               cart_cs, cart_addr, cart_wdata, cart_wdata_send
    );
endinterface

// File: rtl/cart_bus_arb.sv
// Fixed-priority arbiter: lowest set request index wins.
module cart_bus_arb
    import cart_bus_pkg::*;
#(
    parameter int unsigned NCH = NCH_DEF,
    parameter int unsigned IW  = idx_width(NCH_DEF)
) (
    input  logic [NCH-1:0] req_i,
    output logic [NCH-1:0] gnt_o,
    output logic [IW-1:0]  idx_o
);

    // Scan from the top down so the lowest requesting index is left standing.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
                idx_o    = IW'(i);
            end
        end
    end

endmodule

// File: rtl/cart_bus_ctrl.sv
// Multi-requester cartridge-bus controller with its own M-cycle phase counter.
module cart_bus_ctrl
    import cart_bus_pkg::*;
#(
    parameter int unsigned AW        = AW_DEF,
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned NCH       = NCH_DEF,
    parameter int unsigned PHASES    = PHASES_DEF,
    parameter int unsigned WR_PHASE  = 2,
    parameter int unsigned RD_SAMPLE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_en,
    cart_bus_if.slave  bus
);

    localparam int unsigned PW = phase_width(PHASES);
    localparam int unsigned IW = idx_width(NCH);

    // Reject parameter sets that would never pulse or sample.
    if (PHASES < 2) begin : g_bad_phases
        $error("cart_bus_ctrl: PHASES must be at least 2");
    end
    if (WR_PHASE < 1 || WR_PHASE > PHASES - 1) begin : g_bad_wr_phase
        $error("cart_bus_ctrl: WR_PHASE must lie in 1..PHASES-1");
    end
    if (RD_SAMPLE < 1 || RD_SAMPLE > PHASES - 1) begin : g_bad_rd_sample
        $error("cart_bus_ctrl: RD_SAMPLE must lie in 1..PHASES-1");
    end

    bus_state_e      state_q, state_d;
    logic [PW-1:0]   t_q, t_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic            write_q, write_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [NCH-1:0]  rvalid_q, rvalid_d;

    logic [NCH-1:0]  arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            accept_c;
    logic            last_phase_c;
    logic            active_c;

    cart_bus_arb #(
        .NCH (NCH),
        .IW  (IW)
    ) u_arb (
        .req_i (bus.req),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    assign last_phase_c = (t_q == PW'(PHASES - 1));
    assign active_c     = (state_q == ST_BUSY);
    assign accept_c     = cpu_en && (t_q == '0) && !active_c && (|bus.req);

    // State and datapath registers; everything freezes while cpu_en is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            t_q      <= '0;
            owner_q  <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            owner_q  <= owner_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Phase advance, accept latching, read capture and cycle end.
    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        owner_d  = owner_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = '0;

        if (cpu_en) begin
            t_d = last_phase_c ? '0 : t_q + PW'(1);
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        state_d = ST_BUSY;
                        owner_d = arb_idx;
                        write_d = bus.write[arb_idx];
                        addr_d  = bus.addr[32'(arb_idx) * AW +: AW];
                        wdata_d = bus.wdata[32'(arb_idx) * DW +: DW];
                    end
                end
                ST_BUSY: begin
                    if (!write_q && t_q == PW'(RD_SAMPLE)) begin
                        rdata_d  = bus.cart_rdata;
                        rvalid_d = NCH'(1) << owner_q;
                    end
                    if (last_phase_c) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Bus pins decode straight from the held registers.
    assign bus.grant           = accept_c ? arb_gnt : '0;
    assign bus.rvalid          = rvalid_q;
    assign bus.rdata           = rdata_q;
    assign bus.t               = t_q;
    assign bus.n_cart_clk      = (t_q >= PW'(PHASES / 2));
    assign bus.cart_addr       = addr_q;
    assign bus.cart_wdata      = wdata_q;
    assign bus.cart_cs         = active_c && addr_q[AW-1];
    assign bus.cart_write      = active_c && write_q && (t_q == PW'(WR_PHASE));
    assign bus.cart_wdata_send = active_c && write_q;
    assign bus.cart_read       = !(active_c && write_q);

endmodule

// File: tb/tb_cart_bus_ctrl.sv
// Directed bench for cart_bus_ctrl: default 4-phase instance plus an 8-phase one.
module tb_cart_bus_ctrl;
    import cart_bus_pkg::*;

    logic clk;
    logic reset;
    logic cpu_en;

    int n_vec;
    int n_err;
    int ph4;
    int ph8;

    cart_bus_if #(.AW(16), .DW(8), .NCH(2), .PW(2)) bus4 ();
    cart_bus_if #(.AW(16), .DW(8), .NCH(2), .PW(3)) bus8 ();

    cart_bus_ctrl #(
        .AW(16), .DW(8), .NCH(2), .PHASES(4), .WR_PHASE(2), .RD_SAMPLE(3)
    ) u_dut4 (
        .clk    (clk),
        .reset  (reset),
        .cpu_en (cpu_en),
        .bus    (bus4)
    );

    cart_bus_ctrl #(
        .AW(16), .DW(8), .NCH(2), .PHASES(8), .WR_PHASE(5), .RD_SAMPLE(6)
    ) u_dut8 (
        .clk    (clk),
        .reset  (reset),
        .cpu_en (cpu_en),
        .bus    (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock; the bench's own phase model follows reset and cpu_en.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            ph4 = 0;
            ph8 = 0;
        end else if (cpu_en) begin
            ph4 = (ph4 + 1) % 4;
            ph8 = (ph8 + 1) % 8;
        end
        #1;
    endtask

    task automatic set_req4(input int ch, input cart_req_t r);
        bus4.write[ch]          = r.write;
        bus4.addr[ch*16 +: 16]  = r.addr;
        bus4.wdata[ch*8 +: 8]   = r.wdata;
    endtask

    task automatic set_req8(input int ch, input cart_req_t r);
        bus8.write[ch]          = r.write;
        bus8.addr[ch*16 +: 16]  = r.addr;
        bus8.wdata[ch*8 +: 8]   = r.wdata;
    endtask

    task automatic to_phase4_zero();
        for (int k = 0; k < 4 && ph4 != 0; k++) step();
    endtask

    task automatic to_phase8_zero();
        for (int k = 0; k < 8 && ph8 != 0; k++) step();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        ph4 = 0;
        ph8 = 0;
        reset = 1'b1;
        cpu_en = 1'b1;
        bus4.req = '0; bus4.write = '0; bus4.addr = '0; bus4.wdata = '0; bus4.cart_rdata = '0;
        bus8.req = '0; bus8.write = '0; bus8.addr = '0; bus8.wdata = '0; bus8.cart_rdata = '0;
        step();
        step();

        // Reset state
        check("rst_t", bus4.t, 0);
        check("rst_cs", bus4.cart_cs, 0);
        check("rst_write", bus4.cart_write, 0);
        check("rst_send", bus4.cart_wdata_send, 0);
        check("rst_read", bus4.cart_read, 1);
        check("rst_nclk", bus4.n_cart_clk, 0);
        check("rst_rvalid", bus4.rvalid, 0);
        check("rst_rdata", bus4.rdata, 0);
        check("rst_addr", bus4.cart_addr, 0);
        check("rst8_nclk", bus8.n_cart_clk, 0);

        // Channel 0 read of 0x8123, cartridge returns 0x5A
        reset = 1'b0;
        bus4.req = 2'b01;
        set_req4(0, '{write: 1'b0, addr: 16'h8123, wdata: 8'h00});
        bus4.cart_rdata = 8'h5A;
        #1;
        check("rd_grant", bus4.grant, 2'b01);
        for (int k = 1; k <= 3; k++) begin
            step();
            bus4.req = '0;
            #1;
            check("rd_t", bus4.t, k);
            check("rd_cs", bus4.cart_cs, 1);
            check("rd_addr", bus4.cart_addr, 16'h8123);
            check("rd_rvalid_early", bus4.rvalid, 0);
        end
        step();
        check("rd_rvalid", bus4.rvalid, 2'b01);
        check("rd_rdata", bus4.rdata, 8'h5A);
        check("rd_cs_idle", bus4.cart_cs, 0);
        step();
        check("rd_rvalid_drop", bus4.rvalid, 0);
        check("rd_rdata_hold", bus4.rdata, 8'h5A);

        // Channel 1 write 0x2000 <- 0x07
        to_phase4_zero();
        bus4.req = 2'b10;
        set_req4(1, '{write: 1'b1, addr: 16'h2000, wdata: 8'h07});
        #1;
        check("wr_grant", bus4.grant, 2'b10);
        for (int k = 1; k <= 3; k++) begin
            step();
            bus4.req = '0;
            #1;
            check("wr_cart_write", bus4.cart_write, (k == 2) ? 1 : 0);
            check("wr_send", bus4.cart_wdata_send, 1);
            check("wr_cs", bus4.cart_cs, 0);
            check("wr_read", bus4.cart_read, 0);
            check("wr_wdata", bus4.cart_wdata, 8'h07);
            check("wr_addr", bus4.cart_addr, 16'h2000);
        end
        step();
        check("wr_send_end", bus4.cart_wdata_send, 0);
        check("wr_read_end", bus4.cart_read, 1);
        check("wr_no_rvalid", bus4.rvalid, 0);
        step();
        check("wr_no_rvalid2", bus4.rvalid, 0);

        // Both channels read at once: fixed priority then back-to-back
        to_phase4_zero();
        bus4.req = 2'b11;
        set_req4(0, '{write: 1'b0, addr: 16'h9000, wdata: 8'h00});
        set_req4(1, '{write: 1'b0, addr: 16'hA000, wdata: 8'h00});
        bus4.cart_rdata = 8'h11;
        #1;
        check("arb_grant0", bus4.grant, 2'b01);
        step();
        bus4.req = 2'b10;
        #1;
        check("arb_grant_mid", bus4.grant, 2'b00);
        check("arb_addr0", bus4.cart_addr, 16'h9000);
        step();
        step();
        check("arb_cs0", bus4.cart_cs, 1);
        step();
        check("arb_t0", bus4.t, 0);
        check("arb_cs_gap", bus4.cart_cs, 0);
        check("arb_rvalid0", bus4.rvalid, 2'b01);
        check("arb_rdata0", bus4.rdata, 8'h11);
        check("arb_grant1", bus4.grant, 2'b10);
        bus4.cart_rdata = 8'h22;
        step();
        bus4.req = '0;
        #1;
        check("arb_cs1", bus4.cart_cs, 1);
        check("arb_addr1", bus4.cart_addr, 16'hA000);
        step();
        step();
        step();
        check("arb_rvalid1", bus4.rvalid, 2'b10);
        check("arb_rdata1", bus4.rdata, 8'h22);

        // Stall with cpu_en low at phase 2 of a write
        to_phase4_zero();
        cpu_en = 1'b0;
        bus4.req = 2'b01;
        set_req4(0, '{write: 1'b1, addr: 16'h4000, wdata: 8'h3C});
        #1;
        check("stall_no_grant", bus4.grant, 0);
        cpu_en = 1'b1;
        #1;
        check("stall_grant", bus4.grant, 2'b01);
        step();
        bus4.req = '0;
        step();
        check("stall_t2", bus4.t, 2);
        check("stall_wr_pre", bus4.cart_write, 1);
        cpu_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("stall_t", bus4.t, 2);
            check("stall_wr", bus4.cart_write, 1);
        end
        cpu_en = 1'b1;
        step();
        check("stall_t3", bus4.t, 3);
        check("stall_wr_off", bus4.cart_write, 0);
        check("stall_send3", bus4.cart_wdata_send, 1);
        step();
        check("stall_end_t", bus4.t, 0);
        check("stall_end_send", bus4.cart_wdata_send, 0);

        // Reset at phase 2 of a read aborts it
        bus4.req = 2'b01;
        set_req4(0, '{write: 1'b0, addr: 16'h8888, wdata: 8'h00});
        bus4.cart_rdata = 8'h77;
        step();
        bus4.req = '0;
        step();
        check("rr_t2", bus4.t, 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rr_t", bus4.t, 0);
        check("rr_cs", bus4.cart_cs, 0);
        check("rr_addr", bus4.cart_addr, 0);
        check("rr_read", bus4.cart_read, 1);
        check("rr_rdata", bus4.rdata, 0);
        check("rr_rvalid", bus4.rvalid, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_no_rvalid", bus4.rvalid, 0);
        end
        check("rr_t_model", bus4.t, 32'(ph4));

        // 8-phase instance: write timing and n_cart_clk
        to_phase8_zero();
        bus8.req = 2'b01;
        set_req8(0, '{write: 1'b1, addr: 16'h8001, wdata: 8'hAB});
        #1;
        check("p8_wr_grant", bus8.grant, 2'b01);
        for (int k = 1; k <= 7; k++) begin
            step();
            bus8.req = '0;
            #1;
            check("p8_t", bus8.t, k);
            check("p8_nclk", bus8.n_cart_clk, (k >= 4) ? 1 : 0);
            check("p8_cart_write", bus8.cart_write, (k == 5) ? 1 : 0);
        end
        step();

        // 8-phase read: rvalid seven clocks after grant
        bus8.req = 2'b01;
        set_req8(0, '{write: 1'b0, addr: 16'h8555, wdata: 8'h00});
        bus8.cart_rdata = 8'h99;
        #1;
        check("p8_rd_grant", bus8.grant, 2'b01);
        check("p8_nclk0", bus8.n_cart_clk, 0);
        for (int k = 1; k <= 7; k++) begin
            step();
            bus8.req = '0;
            #1;
            check("p8_rvalid", bus8.rvalid, (k == 7) ? 2'b01 : 2'b00);
        end
        check("p8_rdata", bus8.rdata, 8'h99);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cart_bus_ctrl.md
# cart_bus_ctrl

Parametrised cartridge-bus controller: the next-generation replacement for the single-requester cartridge interface. It arbitrates up to NCH requesters (CPU, OAM/HDMA DMA, ...) onto one external cartridge bus and generates its own M-cycle phase counter. It registers address, data and direction for the whole bus cycle and captures read data at a programmable phase. It sits between the console's address decoder/DMA engines and the cartridge pins.

## Interface
Parameters:
- AW, 16, address width
- DW, 8, data width
- NCH, 2, number of requesters; index 0 has highest priority (CPU)
- PHASES, 4, clock-enabled steps per bus cycle (≥2)
- WR_PHASE, 2, phase at which cart_write pulses (1..PHASES-1)
- RD_SAMPLE, 3, phase at which cart_rdata is sampled (1..PHASES-1)

Ports (PW = max(1, $clog2(PHASES))):
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_en  in  1  phase-advance enable; all state holds when low
- req  in  NCH  per-requester access request, held until granted
- write  in  NCH  per-requester direction (1 = write)
- addr  in  NCH*AW  packed per-requester address, channel i at [i*AW +: AW]
- wdata  in  NCH*DW  packed per-requester write data
- grant  out  NCH  one-hot accept strobe, one clk wide
- rvalid  out  NCH  one-hot read-complete strobe, one clk wide
- rdata  out  DW  captured read data, held until next capture
- t  out  PW  current phase
- n_cart_clk  out  1  cartridge clock, high when t ≥ PHASES/2
- cart_write  out  1  write strobe
- cart_read  out  1  read enable
- cart_cs  out  1  chip select
- cart_addr  out  AW  bus address
- cart_wdata  out  DW  bus write data
- cart_wdata_send  out  1  data-pin output enable
- cart_rdata  in  DW  bus read data

## Operation
- Phase counter t: on cpu_en, t ← (t == PHASES-1) ? 0 : t+1.
- Accept: on a clk with cpu_en & t == 0 & |req, the lowest set req index i wins. On that edge, latch owner ← i, write_reg ← write[i], addr_reg ← addr[i], wdata_reg ← wdata[i], active ← 1. grant[i] is asserted combinationally during that clk only.
- Transaction end: active clears on the edge where t goes from PHASES-1 to 0. The bus is idle for all of phase 0. A new accept in that phase 0 gives back-to-back cycles.
- Outputs (combinational from registers):
  - cart_addr = addr_reg (holds the last address when idle)
  - cart_wdata = wdata_reg
  - cart_cs = active & addr_reg[AW-1]
  - cart_write = active & write_reg & (t == WR_PHASE)
  - cart_wdata_send = active & write_reg
  - cart_read = ~(active & write_reg)
- Read capture: on cpu_en & active & ~write_reg & t == RD_SAMPLE: rdata ← cart_rdata, and rvalid[owner] is asserted on the following clk for one clk. Writes produce no rvalid.
- cpu_en low: t, active, and all registers freeze. Outputs hold. No grant, capture or rvalid occurs.
- Requests at phases ≠ 0 wait. Losing requesters keep req asserted and are re-arbitrated at the next phase 0. No fairness beyond fixed priority.
- Reset mid-transaction aborts it. Any pending rvalid is dropped.
- Reset values: t=0, active=0, owner=0, write_reg=0, addr_reg=0, wdata_reg=0, rdata=0, rvalid=0. Hence cart_cs=0, cart_write=0, cart_wdata_send=0, cart_read=1, n_cart_clk=0.

## Timing
- Accept edge: cart_addr and cart_cs are valid from the next clk (t=1).
- cart_write is high for all clks with t == WR_PHASE while cpu_en is stalled low.
- Read latency: RD_SAMPLE enabled steps after accept, plus 1 clk, to rvalid. rdata is valid from the same clk as rvalid.
- Maximum throughput: one transaction per PHASES enabled steps.

## Structure
- Package cart_bus_pkg holds:
  - default AW/DW/PHASES constants
  - typedef cart_req_t {write, addr, wdata}
  - localparam functions for PW
- Sub-module cart_bus_arb holds the fixed-priority NCH-way arbiter: req in, one-hot grant out, plus an encoded index.
- Elaboration-time assertions: PHASES ≥ 2; WR_PHASE and RD_SAMPLE in 1..PHASES-1.

## Test plan
- Defaults, cpu_en=1, ch0 reads 0x8123 with cart_rdata=0x5A at t=3:
  - grant[0] pulses at t=0
  - cart_cs=1 and cart_addr=0x8123 at t=1..3
  - rvalid[0] and rdata=0x5A one clk after t=3
- ch1 writes 0x2000←0x07: cart_write high only at t=2; cart_wdata_send high at t=1..3; cart_cs=0 (addr bit15=0); no rvalid.
- Both channels request at t=0: ch0 is granted. ch1 is granted at the next phase 0, with back-to-back cycles and cs dropping only during phase 0.
- cpu_en low for 5 clks at t=2 during a write: t stays 2 and cart_write stays high for 5 clks; the cycle then completes normally.
- Reset asserted at t=2 of a read: on the next clk all outputs take reset values, and no rvalid is emitted.
- PHASES=8, WR_PHASE=5, RD_SAMPLE=6: n_cart_clk is high for t=4..7, cart_write pulses at t=5, and rvalid arrives 7 clks after grant.
